pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Consumer side of the load-use hazard interface: accepts the stall request from the hazard detection unit and a flush request from branch resolution, and applies them to the front of the 5-stage pipeline. Owns the PC register and the IF/ID pipeline register, and drives the ID/EX control-zeroing select. Keeps saturating stall and flush event counters for performance debug.

## Interface
- WIDTH, 32, datapath / PC width
- RESET_PC, 0, PC value loaded on reset
- NOP, 32'h00000000, instruction word written into IF/ID on flush/reset
- CNT_W, 16, width of each event counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall_req  in  1  load-use stall from hazard unit (ID/EX.MemRead & rt match)
- flush_req  in  1  branch/jump taken; redirect fetch
- branch_target  in  WIDTH  redirect address, sampled when flush_req=1
- imem_instr  in  32  instruction fetched at current pc
- clr_cnt  in  1  synchronous clear of both counters
- pc  out  WIDTH  current fetch address (registered)
- pc_write  out  1  PC update enable this cycle (combinational)
- if_id_write  out  1  IF/ID update enable this cycle (combinational)
- if_id_instr  out  32  IF/ID instruction (registered)
- if_id_pc4  out  WIDTH  IF/ID PC+4 (registered)
- if_id_valid  out  1  IF/ID holds a real instruction (registered)
- id_ex_bubble  out  1  force ID/EX control fields to 0 (combinational)
- stall_cnt  out  CNT_W  applied-stall cycle count
- flush_cnt  out  CNT_W  flush event count

## Operation
- Two-state FSM encoded by if_id_valid: VALID (1), BUBBLE (0).
- Per-cycle priority: flush > stall > advance.
- stall_eff = stall_req & if_id_valid & ~flush_req. In BUBBLE, stall_req is ignored (IF/ID holds NOP; rs/rt=0 can falsely match).
- Flush (flush_req=1, either state): pc <= {branch_target[WIDTH-1:2], 2'b00}; if_id_instr <= NOP; if_id_pc4 <= 0; next state BUBBLE; flush_cnt++; id_ex_bubble=1; pc_write=1, if_id_write=1.
- Stall (stall_eff=1): pc, if_id_instr, if_id_pc4 held; state held VALID; id_ex_bubble=1; pc_write=0, if_id_write=0; stall_cnt++.
- Advance (otherwise): pc <= pc+4; if_id_instr <= imem_instr; if_id_pc4 <= pc+4; next state VALID; id_ex_bubble=0; pc_write=1, if_id_write=1.
- Consecutive stall_req cycles are each honoured; one stall_cnt increment per cycle.
- pc+4 wraps modulo 2^WIDTH; no trap.
- Counters saturate at all-ones; clr_cnt clears both to 0 and takes priority over an increment in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous, immediate): pc=RESET_PC, if_id_instr=NOP, if_id_pc4=0, if_id_valid=0 (BUBBLE), stall_cnt=0, flush_cnt=0. With inputs low: pc_write=1, if_id_write=1, id_ex_bubble=0.
- Reset deassertion: first rising edge after rst_n=1 performs a normal advance.
- All registered outputs update on rising clk; pc_write, if_id_write, id_ex_bubble settle in the same cycle as stall_req/flush_req (zero latency).
- Load-use stall: one cycle of hold per asserted cycle; the held instruction re-enters ID next cycle with hazard cleared.
- Flush latency: branch_target visible on pc one edge after flush_req; if_id_valid=0 for exactly one cycle unless flush repeats.
- Reset mid-stall or mid-flush: all state discarded; reset values apply regardless of inputs.

## Test plan
- Reset then 4 free-run cycles, RESET_PC=0, imem_instr=32'h8C220004 -> pc=0,4,8,12,16; if_id_pc4=4,8,12,16; if_id_valid=1 from cycle 1; counters 0.
- stall_req=1 for one cycle at pc=8 (VALID) -> id_ex_bubble=1, pc_write=0, pc stays 8, if_id_instr unchanged, stall_cnt=1; next cycle pc=12.
- flush_req=1, branch_target=32'h00000103 -> next pc=32'h00000100, if_id_instr=NOP, if_id_valid=0, flush_cnt=1; stall_req=1 in following cycle -> ignored, pc=32'h104, stall_cnt unchanged.
- flush_req=1 and stall_req=1 same cycle -> flush wins: pc=target, stall_cnt unchanged, flush_cnt+1.
- pc=32'hFFFFFFFC advance -> pc=0, if_id_pc4=0; CNT_W=2 with 5 stalls -> stall_cnt=3; clr_cnt with stall -> 0.
- rst_n pulled low mid-clock during stall -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Front-of-pipeline hazard consumer: owns the PC and IF/ID registers and
// applies flush > load-use stall > advance each cycle, with saturating event counters.
module pipeline_stall_ctrl #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter logic [31:0]        NOP      = 32'h00000000,
  parameter int                 CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [31:0]      imem_instr,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] pc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [31:0]      if_id_instr,
  output logic [WIDTH-1:0] if_id_pc4,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The FSM state is exactly the IF/ID valid bit.
  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] r_pc4;
  logic [WIDTH-1:0] w_pc4_next;
  logic [31:0]      r_instr;
  logic [31:0]      w_instr_next;
  logic             w_stall_eff;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_bubble;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_pc_plus4  = r_pc + WIDTH'(4);
  // A NOP in IF/ID has rs/rt = 0 and can falsely match, so BUBBLE ignores stall_req.
  assign w_stall_eff = stall_req & (r_state == ST_VALID) & ~flush_req;

  always_comb begin
    w_state_next  = ST_VALID;
    w_pc_next     = w_pc_plus4;
    w_pc4_next    = w_pc_plus4;
    w_instr_next  = imem_instr;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_bubble      = 1'b0;
    if (flush_req) begin
      w_state_next = ST_BUBBLE;
      w_pc_next    = {branch_target[WIDTH-1:2], 2'b00};
      w_pc4_next   = '0;
      w_instr_next = NOP;
      w_bubble     = 1'b1;
    end else if (w_stall_eff) begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_pc4_next    = r_pc4;
      w_instr_next  = r_instr;
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_bubble      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BUBBLE;
      r_pc    <= RESET_PC;
      r_pc4   <= '0;
      r_instr <= NOP;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_pc4   <= w_pc4_next;
      r_instr <= w_instr_next;
    end
  end

  // Clear beats increment; increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_eff && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_req && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc           = r_pc;
  assign pc_write     = w_pc_write;
  assign if_id_write  = w_if_id_write;
  assign if_id_instr  = r_instr;
  assign if_id_pc4    = r_pc4;
  assign if_id_valid  = (r_state == ST_VALID);
  assign id_ex_bubble = w_bubble;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed vector table, asynchronous-reset check and randomized run against
// a rule-level model for pipeline_stall_ctrl (plus a CNT_W=2 instance for saturation).
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req, flush_req, clr_cnt;
  logic [31:0] branch_target, imem_instr;

  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        pc_write, if_id_write, if_id_valid, id_ex_bubble;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] d2_pc, d2_if_id_instr, d2_if_id_pc4;
  logic        d2_pc_write, d2_if_id_write, d2_if_id_valid, d2_id_ex_bubble;
  logic [1:0]  d2_stall_cnt, d2_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .branch_target(branch_target), .imem_instr(imem_instr), .clr_cnt(clr_cnt),
    .pc(pc), .pc_write(pc_write), .if_id_write(if_id_write), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_stall_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .branch_target(branch_target), .imem_instr(imem_instr), .clr_cnt(clr_cnt),
    .pc(d2_pc), .pc_write(d2_pc_write), .if_id_write(d2_if_id_write),
    .if_id_instr(d2_if_id_instr), .if_id_pc4(d2_if_id_pc4), .if_id_valid(d2_if_id_valid),
    .id_ex_bubble(d2_id_ex_bubble), .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s, f, c;
    logic [31:0] tgt, im;
    logic        e_pw, e_bub;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid;
    int          e_sc, e_fc, e_sc2;
  } vec_t;

  vec_t vecs[16];

  // Rule-level model state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_sc, m_fc, m_sc2, m_fc2;

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
  endtask

  function automatic int action();  // 2 = flush, 1 = honoured stall, 0 = advance
    if (flush_req) return 2;
    if (stall_req && m_valid) return 1;
    return 0;
  endfunction

  task automatic model_step(input int act);
    if (act == 2) begin
      m_pc = branch_target & 32'hFFFF_FFFC; m_pc4 = 0; m_instr = 0; m_valid = 1'b0;
    end else if (act == 0) begin
      m_pc4 = m_pc + 32'd4; m_pc = m_pc4; m_instr = imem_instr; m_valid = 1'b1;
    end
    if (clr_cnt) begin
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else if (act == 1) begin
      m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
      m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
    end else if (act == 2) begin
      m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : m_fc2;
    end
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic rand_cycle(input int idx);
    int act;
    stall_req     = ($urandom_range(0, 2) == 0);
    flush_req     = ($urandom_range(0, 5) == 0);
    clr_cnt       = ($urandom_range(0, 19) == 0);
    branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
    imem_instr    = $urandom;
    #1;
    act = action();
    chk($sformatf("rnd%0d pc_write", idx), {63'b0, pc_write}, {63'b0, act != 1});
    chk($sformatf("rnd%0d if_id_write", idx), {63'b0, if_id_write}, {63'b0, act != 1});
    chk($sformatf("rnd%0d bubble", idx), {63'b0, id_ex_bubble}, {63'b0, act != 0});
    @(posedge clk); #1;
    model_step(act);
    chk($sformatf("rnd%0d state", idx), {pc, if_id_pc4},
        {m_pc, m_pc4});
    chk($sformatf("rnd%0d instr/valid", idx), {31'b0, if_id_valid, if_id_instr},
        {31'b0, m_valid, m_instr});
    chk($sformatf("rnd%0d counters", idx), {stall_cnt, flush_cnt, 28'b0, d2_stall_cnt, d2_flush_cnt},
        {m_sc[15:0], m_fc[15:0], 28'b0, m_sc2[1:0], m_fc2[1:0]});
    @(negedge clk);
  endtask

  initial begin
    //        s     f     c     tgt            im             pw    bub   pc             pc4            instr          v     sc fc sc2
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8C220004, 1'b1, 1'b0, 32'h4,         32'h4,         32'h8C220004, 1'b1, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8C2200A1, 1'b1, 1'b0, 32'h8,         32'h8,         32'h8C2200A1, 1'b1, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200A2, 1'b0, 1'b1, 32'h8,         32'h8,         32'h8C2200A1, 1'b1, 1, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8C2200A3, 1'b1, 1'b0, 32'hC,         32'hC,         32'h8C2200A3, 1'b1, 1, 0, 1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h103,       32'h8C2200A4, 1'b1, 1'b1, 32'h100,       32'h0,         32'h0,        1'b0, 1, 1, 1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200A5, 1'b1, 1'b0, 32'h104,       32'h104,       32'h8C2200A5, 1'b1, 1, 1, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h202,       32'h8C2200A6, 1'b1, 1'b1, 32'h200,       32'h0,         32'h0,        1'b0, 1, 2, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8C2200A7, 1'b1, 1'b0, 32'h204,       32'h204,       32'h8C2200A7, 1'b1, 1, 2, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF,  32'h8C2200A8, 1'b1, 1'b1, 32'hFFFFFFFC,  32'h0,         32'h0,        1'b0, 1, 3, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8C2200A9, 1'b1, 1'b0, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 1, 3, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'h8C2200AA, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200AB, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 1, 0, 1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200AC, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 2, 0, 2};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200AD, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 3, 0, 3};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200AE, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 4, 0, 3};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8C2200AF, 1'b0, 1'b1, 32'h0,         32'h0,         32'h8C2200A9, 1'b1, 5, 0, 3};

    rst_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0; clr_cnt = 1'b0;
    branch_target = 32'h0; imem_instr = 32'h8C220004;
    repeat (2) @(negedge clk);
    chk("reset pc/pc4", {pc, if_id_pc4}, 64'h0);
    chk("reset instr/valid", {31'b0, if_id_valid, if_id_instr}, 64'h0);
    chk("reset counters", {32'b0, stall_cnt, flush_cnt}, 64'h0);
    chk("reset comb", {61'b0, pc_write, if_id_write, id_ex_bubble}, 64'h6);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      stall_req = vecs[i].s; flush_req = vecs[i].f; clr_cnt = vecs[i].c;
      branch_target = vecs[i].tgt; imem_instr = vecs[i].im;
      #1;
      chk($sformatf("vec%0d comb", i), {61'b0, pc_write, if_id_write, id_ex_bubble},
          {61'b0, vecs[i].e_pw, vecs[i].e_pw, vecs[i].e_bub});
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc/pc4", i), {pc, if_id_pc4}, {vecs[i].e_pc, vecs[i].e_pc4});
      chk($sformatf("vec%0d instr/valid", i), {31'b0, if_id_valid, if_id_instr},
          {31'b0, vecs[i].e_valid, vecs[i].e_instr});
      chk($sformatf("vec%0d counters", i), {16'b0, stall_cnt, flush_cnt, 14'b0, d2_stall_cnt},
          {16'b0, vecs[i].e_sc[15:0], vecs[i].e_fc[15:0], 14'b0, vecs[i].e_sc2[1:0]});
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a stall cycle
    stall_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pc/pc4", {pc, if_id_pc4}, 64'h0);
    chk("async rst instr/valid/cnt", {if_id_valid, if_id_instr, stall_cnt, flush_cnt[14:0]}, 64'h0);
    stall_req = 1'b0;
    #1;
    chk("async rst comb", {61'b0, pc_write, if_id_write, id_ex_bubble}, 64'h6);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 400; i++) rand_cycle(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
